tiger_hex_led_ctrl: RTL and testbench

- Parametrised Avalon-MM slave peripheral that drives the board 7-segment digits and the red/green LED banks from the tiger SOPC.
- Generalises the fixed HexLED/RedLED/GreenLED ports: digit count and LED widths are parameters.
- Adds per-digit blanking, per-digit hardware blink with a programmable divider, and optional register readback.
- Sits beside the SDRAM controller on the CPU data bus; the board-level wrapper connects its outputs to HEX/LEDR/LEDG pins.

---
 rtl/tiger_hex_led_ctrl.sv | 175 +++++++++++++++++
 tb/tb_tiger_hex_led_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/tiger_hex_led_ctrl.sv
// Avalon-MM peripheral: 7-seg digits with per-digit blank/blink, red/green LED banks.
// Writes land at the write edge; outputs follow one cycle later. Readback build: TIGER_HEX_LED_READBACK_EN.
module tiger_hex_led_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int LEDR_W     = 18,
    parameter int LEDG_W     = 9,
    parameter int DIV_W      = 24,
    parameter int BLINK_RST  = 12500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              address,
    input  logic                    write,
    input  logic [31:0]             writedata,
    input  logic                    read,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [LEDR_W-1:0]       ledr,
    output logic [LEDG_W-1:0]       ledg
);

    localparam int DW = 4 * NUM_DIGITS;

    logic [DW-1:0]           data_q, data_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic [LEDR_W-1:0]       ledr_reg_q, ledr_reg_d;
    logic [LEDG_W-1:0]       ledg_reg_q, ledg_reg_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [LEDR_W-1:0]       ledr_q, ledr_d;
    logic [LEDG_W-1:0]       ledg_q, ledg_d;
    logic                    div_wr;

    function automatic logic [6:0] hex_font(input logic [3:0] n);
        logic [6:0] seg;
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign div_wr = write && (address == 3'd4);

    always_comb begin
        data_d     = data_q;
        blank_d    = blank_q;
        blink_d    = blink_q;
        ledr_reg_d = ledr_reg_q;
        ledg_reg_d = ledg_reg_q;
        div_d      = div_q;
        if (write) begin
            case (address)
                3'd0: data_d = writedata[DW-1:0];
                3'd1: begin
                    blank_d = writedata[NUM_DIGITS-1:0];
                    blink_d = writedata[8 +: NUM_DIGITS];
                end
                3'd2: ledr_reg_d = writedata[LEDR_W-1:0];
                3'd3: ledg_reg_d = writedata[LEDG_W-1:0];
                3'd4: div_d      = writedata[DIV_W-1:0];
                default: ;
            endcase
        end
    end

    // A divider write reloads the counter and pre-empts the terminal-count toggle.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (div_wr) begin
            cnt_d = writedata[DIV_W-1:0];
        end else if (cnt_q == '0) begin
            if (div_q != '0) begin
                cnt_d   = div_q;
                phase_d = ~phase_q;
            end
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_comb begin
        hex_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (blank_q[i] || (blink_q[i] && phase_q))
                hex_d[7*i +: 7] = 7'h7F;
            else
                hex_d[7*i +: 7] = hex_font(data_q[4*i +: 4]);
        end
        ledr_d = ledr_reg_q;
        ledg_d = ledg_reg_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            blank_q    <= '1;
            blink_q    <= '0;
            ledr_reg_q <= '0;
            ledg_reg_q <= '0;
            div_q      <= DIV_W'(BLINK_RST);
            cnt_q      <= DIV_W'(BLINK_RST);
            phase_q    <= 1'b0;
            hex_q      <= '1;
            ledr_q     <= '0;
            ledg_q     <= '0;
        end else begin
            data_q     <= data_d;
            blank_q    <= blank_d;
            blink_q    <= blink_d;
            ledr_reg_q <= ledr_reg_d;
            ledg_reg_q <= ledg_reg_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            hex_q      <= hex_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
        end
    end

    assign hex_out = hex_q;
    assign ledr    = ledr_q;
    assign ledg    = ledg_q;

`ifdef TIGER_HEX_LED_READBACK_EN
    logic [31:0] readdata_q, readdata_d;

    // Reads sample the pre-write state, so a same-cycle write is not visible.
    always_comb begin
        readdata_d = '0;
        if (read) begin
            case (address)
                3'd0: readdata_d = 32'(data_q);
                3'd1: readdata_d = {16'b0, 8'(blink_q), 8'(blank_q)};
                3'd2: readdata_d = 32'(ledr_reg_q);
                3'd3: readdata_d = 32'(ledg_reg_q);
                3'd4: readdata_d = 32'(div_q);
                3'd5: readdata_d = {31'b0, phase_q};
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata_q <= '0;
        else       readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
`else
    logic unused_read;
    assign unused_read = read;
    assign readdata    = '0;
`endif

endmodule

// File: tb/tb_tiger_hex_led_ctrl.sv
// Directed bench for tiger_hex_led_ctrl: an 8-digit and a 4-digit instance on a shared bus.
module tb_tiger_hex_led_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;

    logic [31:0] rd8, rd4;
    logic [55:0] hex8;
    logic [27:0] hex4;
    logic [17:0] ledr8, ledr4;
    logic [8:0]  ledg8, ledg4;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    tiger_hex_led_ctrl u_dut8 (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(rd8),
        .hex_out(hex8), .ledr(ledr8), .ledg(ledg8)
    );

    tiger_hex_led_ctrl #(.NUM_DIGITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(rd4),
        .hex_out(hex4), .ledr(ledr4), .ledg(ledg4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_exp(input logic [31:0] v);
`ifdef TIGER_HEX_LED_READBACK_EN
        return v;
`else
        return 32'(v & 32'h0);
`endif
    endfunction

    function automatic logic [55:0] blink_hex(input int p);
        return {{7{7'h40}}, (p != 0) ? 7'h7F : 7'h40};
    endfunction

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Optional same-cycle write; expected values queued at issue, compared when readdata is valid.
    task automatic do_read(input string tag, input logic [2:0] a, input logic [31:0] e8,
                           input logic [31:0] e4, input logic wr, input logic [31:0] wd);
        exp_q.push_back(64'(rd_exp(e8)));
        exp_q.push_back(64'(rd_exp(e4)));
        address = a; read = 1'b1; write = wr; writedata = wd;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        check({tag, "_rd8"}, 64'(rd8), exp_q.pop_front());
        check({tag, "_rd4"}, 64'(rd4), exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        check("por_hex8", 64'(hex8), {56{1'b1}});
        check("por_ledr", 64'(ledr8), 64'h0);
        check("por_rd", 64'(rd8), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // Get blinking, then hit reset mid-cycle
        do_write(3'd1, 32'h0000_FF00);
        do_write(3'd0, 32'h1234_5678);
        do_write(3'd2, 32'h0000_0ABC);
        do_write(3'd3, 32'h0000_0001);
        do_write(3'd4, 32'd2);
        repeat (5) @(negedge clk);
        check("pre_rst_ledr", 64'(ledr8), 64'h0ABC);
        #2 reset = 1'b1;
        #1;
        check("async_rst_hex8", 64'(hex8), {56{1'b1}});
        check("async_rst_ledg", 64'(ledg8), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_hex8", 64'(hex8), {56{1'b1}});
        check("rst_hex4", 64'(hex4), {28{1'b1}});
        check("rst_ledr", 64'(ledr8), 64'h0);
        check("rst_ledg", 64'(ledg8), 64'h0);
        do_read("rst_div", 3'd4, 32'd12500000, 32'd12500000, 1'b0, 32'h0);
        do_read("rst_ctrl", 3'd1, 32'h0000_00FF, 32'h0000_000F, 1'b0, 32'h0);
        do_read("rst_phase", 3'd5, 32'h0, 32'h0, 1'b0, 32'h0);

        // Full font pass on the upper hex digits
        do_write(3'd1, 32'h0);
        do_write(3'd0, 32'h89AB_CDEF);
        check("data_latency_hex8", 64'(hex8), 64'({8{7'h40}}));
        @(negedge clk);
        check("data_hex8", 64'(hex8),
              64'({7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}));
        check("data_hex4", 64'(hex4), 64'({7'h46, 7'h21, 7'h06, 7'h0E}));
        do_read("data", 3'd0, 32'h89AB_CDEF, 32'h0000_CDEF, 1'b0, 32'h0);

        // Over-wide writes are truncated to the configured widths
        do_write(3'd0, 32'hFFFF_FFFF);
        do_write(3'd2, 32'hFFFF_FFFF);
        do_write(3'd3, 32'hFFFF_FFFF);
        @(negedge clk);
        check("ff_hex8", 64'(hex8), 64'({8{7'h0E}}));
        check("ff_hex4", 64'(hex4), 64'({4{7'h0E}}));
        check("ff_ledr8", 64'(ledr8), 64'h3FFFF);
        check("ff_ledr4", 64'(ledr4), 64'h3FFFF);
        check("ff_ledg8", 64'(ledg8), 64'h1FF);
        do_read("ff_data", 3'd0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 32'h0);
        do_read("ff_ledr", 3'd2, 32'h0003_FFFF, 32'h0003_FFFF, 1'b0, 32'h0);

        // Masks above NUM_DIGITS read as zero; all blanked
        do_write(3'd1, 32'hFFFF_FFFF);
        do_read("ctrl_ff", 3'd1, 32'h0000_FFFF, 32'h0000_0F0F, 1'b0, 32'h0);
        check("blank_hex8", 64'(hex8), {56{1'b1}});
        check("blank_hex4", 64'(hex4), {28{1'b1}});

        // Unmapped address
        do_write(3'd6, 32'h0000_1234);
        do_read("unmapped6", 3'd6, 32'h0, 32'h0, 1'b0, 32'h0);
        do_read("after6_data", 3'd0, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 32'h0);
        check("after6_ledr", 64'(ledr8), 64'h3FFFF);

        // Read and write same address together: old value returned
        do_read("rw_ledg", 3'd3, 32'h0000_01FF, 32'h0000_01FF, 1'b1, 32'h0000_00AA);
        do_read("rw_ledg_new", 3'd3, 32'h0000_00AA, 32'h0000_00AA, 1'b0, 32'h0);

        // Blink digit 0 with a 4-cycle half-period (phase is 0 since reset)
        do_write(3'd1, 32'h0000_0100);
        do_write(3'd0, 32'h0);
        do_write(3'd4, 32'd3);
        for (int k = 1; k <= 19; k++) exp_q.push_back(64'(blink_hex(((k - 1) / 4) % 2)));
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            check($sformatf("blink4_c%0d", k), 64'(hex8), exp_q.pop_front());
        end

        // Divider write lands on terminal count: no toggle, next toggle 6 cycles on
        address = 3'd4; writedata = 32'd5; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        check("div_wr_c20", 64'(hex8), 64'(blink_hex(0)));
        for (int j = 21; j <= 27; j++) exp_q.push_back(64'(blink_hex(((j - 21) / 6) % 2)));
        for (int j = 21; j <= 27; j++) begin
            @(negedge clk);
            check($sformatf("blink6_c%0d", j), 64'(hex8), exp_q.pop_front());
        end
        do_read("phase_hi", 3'd5, 32'h1, 32'h1, 1'b0, 32'h0);
        for (int j = 29; j <= 34; j++) exp_q.push_back(64'(blink_hex(((j - 21) / 6) % 2)));
        for (int j = 29; j <= 34; j++) begin
            @(negedge clk);
            check($sformatf("blink6_c%0d", j), 64'(hex8), exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
